// File: rtl/mem_req_pkg.sv
// Shared constants and FSM encoding for the memory request controller.
package mem_req_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ADDR_WIDTH = 16;
  localparam int unsigned DEF_TIMEOUT    = 64;

  // Read data returned on a timed-out request.
  localparam logic [7:0] ERR_FILL = 8'hFF;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_WAIT  = ST_WAIT,
    S_RESP  = ST_RESP
  } state_t;

endpackage

// File: rtl/mem_req_ctrl_if.sv
// Core request/response handshake plus the memory_top command/status bus.
interface mem_req_ctrl_if
  import mem_req_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;
  logic                  mem_rd_enable;
  logic                  mem_wr_enable;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic                  mem_busy;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  // Environment side: the core plus memory_top.
  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_busy, mem_rd_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_rd_enable, mem_wr_enable, mem_addr, mem_wr_data
  );

  // Controller side.
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_busy, mem_rd_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_rd_enable, mem_wr_enable, mem_addr, mem_wr_data
  );
endinterface

// File: rtl/mem_req_watchdog.sv
// Clearable saturating cycle counter flagging TIMEOUT-1 elapsed cycles.
module mem_req_watchdog
  import mem_req_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expired
);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  // Count up while enabled, stick at TIMEOUT, clear has priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != CW'(TIMEOUT))) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == CW'(TIMEOUT - 1));
endmodule

// File: rtl/mem_req_ctrl.sv
// Single-outstanding request controller between the core bus port and memory_top.
module mem_req_ctrl
  import mem_req_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input logic           clk,
  input logic           reset,
  mem_req_ctrl_if.slave bus
);
  state_t                state;
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  ready_q;
  logic                  resp_valid_q;
  logic                  resp_err_q;
  logic                  wd_clear;
  logic                  wd_inc;
  logic                  wd_expired;

  // Watchdog runs only in WAIT; it is zero on the first WAIT cycle.
  assign wd_clear = (state != S_WAIT);
  assign wd_inc   = (state == S_WAIT);

  mem_req_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .inc     (wd_inc),
    .expired (wd_expired)
  );

  // FSM with request capture and registered response/handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.req_valid && ready_q) begin
            wr_q    <= bus.req_write;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            ready_q <= 1'b0;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!bus.mem_busy) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Completion wins over timeout when both land on the same cycle.
          if (!bus.mem_busy) begin
            rdata_q      <= wr_q ? '0 : bus.mem_rd_data;
            resp_err_q   <= 1'b0;
            resp_valid_q <= 1'b1;
            state        <= S_RESP;
          end else if (wd_expired) begin
            rdata_q      <= DATA_WIDTH'(ERR_FILL);
            resp_err_q   <= 1'b1;
            resp_valid_q <= 1'b1;
            state        <= S_RESP;
          end
        end
        S_RESP: begin
          ready_q <= 1'b1;
          state   <= S_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  // Single-cycle enable decode so memory_top sees exactly one strobe per request.
  assign bus.mem_rd_enable = (state == S_ISSUE) && !bus.mem_busy && !wr_q;
  assign bus.mem_wr_enable = (state == S_ISSUE) && !bus.mem_busy &&  wr_q;

  assign bus.mem_addr    = addr_q;
  assign bus.mem_wr_data = wdata_q;
  assign bus.req_ready   = ready_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_rdata  = rdata_q;
  assign bus.resp_err    = resp_err_q;
endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl: vector table plus multi-cycle sequences.
module tb_mem_req_ctrl;

  logic clk = 1'b0;
  logic reset;

  mem_req_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) bus ();

  mem_req_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .TIMEOUT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        write;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        busy;
    logic [7:0]  rdata;
    logic        e_ready;
    logic        e_rd;
    logic        e_wr;
    logic [15:0] e_addr;
    logic [7:0]  e_wdata;
    logic        e_rv;
    logic [7:0]  e_rdata;
    logic        e_err;
  } vec_t;

  vec_t vecs [20];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic w, input logic [15:0] a,
                       input logic [7:0] wd, input logic b, input logic [7:0] rd);
    bus.req_valid   = v;
    bus.req_write   = w;
    bus.req_addr    = a;
    bus.req_wdata   = wd;
    bus.mem_busy    = b;
    bus.mem_rd_data = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'(v.e_ready));
    chk({tag, "_rd_en"}, 32'(bus.mem_rd_enable), 32'(v.e_rd));
    chk({tag, "_wr_en"}, 32'(bus.mem_wr_enable), 32'(v.e_wr));
    chk({tag, "_addr"}, 32'(bus.mem_addr), 32'(v.e_addr));
    chk({tag, "_wdata"}, 32'(bus.mem_wr_data), 32'(v.e_wdata));
    chk({tag, "_rv"}, 32'(bus.resp_valid), 32'(v.e_rv));
    chk({tag, "_rdata"}, 32'(bus.resp_rdata), 32'(v.e_rdata));
    chk({tag, "_err"}, 32'(bus.resp_err), 32'(v.e_err));
  endtask

  initial begin
    int got;
    int acc;
    int nen;
    int nrv;

    // Read 0x1234 best case, write 0x3C to 0x00FF with 3 busy cycles, read under busy-at-accept.
    //            valid write addr      wdata  busy  rdata  | ready rd    wr    addr      wdata  rv    rdata  err
    vecs[0]  = '{1'b1, 1'b0, 16'h1234, 8'h00, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 16'h1234, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 16'h1234, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 16'h1234, 8'h00, 1'b1, 8'hA5, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 16'h00FF, 8'h3C, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 16'h1234, 8'h00, 1'b0, 8'hA5, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 16'h00FF, 8'h3C, 1'b0, 8'hA5, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 16'h00FF, 8'h3C, 1'b0, 8'hA5, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 16'h00FF, 8'h3C, 1'b0, 8'hA5, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 16'h00FF, 8'h3C, 1'b0, 8'hA5, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 16'h00FF, 8'h3C, 1'b0, 8'hA5, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 16'h00FF, 8'h3C, 1'b1, 8'h00, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 16'h0042, 8'h00, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 16'h00FF, 8'h3C, 1'b0, 8'h00, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 16'h0042, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 16'h0042, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 16'h0042, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 16'h0042, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 16'h0042, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 16'h0042, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 16'h0042, 8'h00, 1'b1, 8'h5A, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b0, 16'h0042, 8'h00, 1'b0, 8'h5A, 1'b0};

    reset = 1'b1;
    drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    #3;
    chk_all("rst", '{1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 8'h0,
                     1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 1'b0});
    @(negedge clk);
    reset = 1'b0;
    step();

    // Table: one vector per clock cycle.
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].valid, vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].busy, vecs[i].rdata);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i]);
      step();
    end

    // Timeout: busy stuck high after the read enable (TIMEOUT=8).
    drive(1'b1, 1'b0, 16'h0777, 8'h00, 1'b0, 8'h33);
    #1;
    chk("to_accept_ready", 32'(bus.req_ready), 32'd1);
    step();
    drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h33);
    #1;
    chk("to_enable", 32'(bus.mem_rd_enable), 32'd1);
    chk("to_addr", 32'(bus.mem_addr), 32'h0777);
    step();
    got = 0;
    for (int k = 1; k <= 20; k++) begin
      drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'h33);
      #1;
      if (bus.mem_rd_enable || bus.mem_wr_enable) chk("to_extra_enable", 32'd1, 32'd0);
      if (bus.resp_valid) begin
        got = k;
        break;
      end
      step();
    end
    chk("to_latency", 32'(got), 32'd9);
    chk("to_rdata", 32'(bus.resp_rdata), 32'hFF);
    chk("to_err", 32'(bus.resp_err), 32'd1);
    step();
    drive(1'b1, 1'b0, 16'h0100, 8'h00, 1'b0, 8'h11);
    #1;
    chk("to_rv_one_cycle", 32'(bus.resp_valid), 32'd0);
    chk("to_next_ready", 32'(bus.req_ready), 32'd1);
    step();
    drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h11);
    #1;
    chk("to_next_enable", 32'(bus.mem_rd_enable), 32'd1);
    step();
    step();
    #1;
    chk("to_next_rv", 32'(bus.resp_valid), 32'd1);
    chk("to_next_rdata", 32'(bus.resp_rdata), 32'h11);
    chk("to_next_err", 32'(bus.resp_err), 32'd0);
    step();

    // Back-to-back: req_valid held for four reads at 0x20..0x23.
    acc = 0;
    nen = 0;
    nrv = 0;
    for (int c = 0; c < 16; c++) begin
      drive(acc < 4, 1'b0, 16'h0020 + 16'(acc), 8'h00, 1'b0, bus.mem_addr[7:0]);
      #1;
      chk("b2b_ready", 32'(bus.req_ready), 32'((c % 4) == 0));
      chk("b2b_rd_en", 32'(bus.mem_rd_enable), 32'((c % 4) == 1));
      chk("b2b_rv", 32'(bus.resp_valid), 32'((c % 4) == 3));
      if (bus.resp_valid) begin
        chk("b2b_rdata", 32'(bus.resp_rdata), 32'h20 + 32'(nrv));
        nrv++;
      end
      if (bus.mem_rd_enable) nen++;
      if (bus.req_valid && bus.req_ready) acc++;
      step();
    end
    chk("b2b_accepts", 32'(acc), 32'd4);
    chk("b2b_enables", 32'(nen), 32'd4);
    chk("b2b_responses", 32'(nrv), 32'd4);

    // Reset while in WAIT: in-flight request dropped, no response.
    drive(1'b1, 1'b0, 16'h0BEE, 8'h00, 1'b0, 8'h44);
    step();
    drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h44);
    #1;
    chk("rw_enable", 32'(bus.mem_rd_enable), 32'd1);
    step();
    drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'h44);
    step();
    #1;
    reset = 1'b1;
    #1;
    chk_all("rw_rst", '{1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 8'h0,
                        1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 1'b0});
    step();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h44);
      #1;
      chk("rw_no_rv", 32'(bus.resp_valid), 32'd0);
      chk("rw_ready", 32'(bus.req_ready), 32'd1);
      step();
    end
    drive(1'b1, 1'b0, 16'h0C0D, 8'h00, 1'b0, 8'h77);
    step();
    drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h77);
    #1;
    chk("rw_new_enable", 32'(bus.mem_rd_enable), 32'd1);
    chk("rw_new_addr", 32'(bus.mem_addr), 32'h0C0D);
    step();
    step();
    #1;
    chk("rw_new_rv", 32'(bus.resp_valid), 32'd1);
    chk("rw_new_rdata", 32'(bus.resp_rdata), 32'h77);
    chk("rw_new_err", 32'(bus.resp_err), 32'd0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
